// File: rtl/demux_tdm_sequencer.sv
// ---------------------------------------------------------------------------
// demux_tdm_sequencer
//
// Upstream driver for a 1xNUM_CH demultiplexer (din, sel -> y[NUM_CH-1:0]).
// Accepts NUM_CH-bit words over a valid/ready handshake. Each word is sent
// out LSB-first, one bit per clock, with sel carrying the bit index so that
// bit k of a word lands on demux output y[k].
//
// A one-word holding register sits in front of the shift engine. It lets the
// next word be loaded on the same edge the current word finishes, so
// back-to-back words stream with no idle cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     upstream word valid
//   in_ready     block can accept a word this cycle (combinational)
//   in_data      word to distribute; bit k goes to channel k
//   flush        synchronous clear of the hold register and the engine
//   din          serial data to the demux (registered)
//   sel          demux channel select (registered)
//   active       din/sel carry a valid bit this cycle (registered)
//   frame_start  one-cycle pulse on the bit-0 cycle of each word (registered)
//   frame_done   one-cycle pulse on the last-bit cycle of each word (registered)
// ---------------------------------------------------------------------------
module demux_tdm_sequencer #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] in_data,
    input  logic              flush,
    output logic              din,
    output logic [SEL_W-1:0]  sel,
    output logic              active,
    output logic              frame_start,
    output logic              frame_done
);

    // sel indexes the word directly, so the word must be exactly 2**SEL_W wide.
    generate
        if (NUM_CH != (1 << SEL_W)) begin : g_bad_params
            $error("demux_tdm_sequencer: NUM_CH must equal 2**SEL_W");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NUM_CH-1:0]  shift_reg;
    logic [NUM_CH-1:0]  shift_nxt;
    logic [NUM_CH-1:0]  hold_reg;
    logic [NUM_CH-1:0]  hold_nxt;
    logic               hold_full;
    logic               hold_full_nxt;

    logic               din_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic               active_nxt;
    logic               frame_start_nxt;
    logic               frame_done_nxt;

    logic               handshake;
    logic               load_point;
    logic               do_load;
    logic [NUM_CH-1:0]  load_word;
    logic [SEL_W-1:0]   sel_inc;

    // Flush blocks acceptance so a word offered during a flush is not lost
    // into a register that is being cleared on the same edge.
    assign in_ready  = !hold_full && !flush;
    assign handshake = in_valid && in_ready;

    // The engine can take a new word when idle or while the last bit of the
    // current word is on the wire.
    assign load_point = (state == IDLE) || ((state == SHIFT) && (sel == LAST_SEL));

    // Wraps modulo 2**SEL_W, which equals NUM_CH, so sel never leaves 0..NUM_CH-1.
    assign sel_inc = sel + 1'b1;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        shift_nxt       = shift_reg;
        hold_nxt        = hold_reg;
        hold_full_nxt   = hold_full;
        din_nxt         = 1'b0;
        sel_nxt         = '0;
        active_nxt      = 1'b0;
        frame_start_nxt = 1'b0;
        frame_done_nxt  = 1'b0;
        do_load         = 1'b0;
        load_word       = '0;

        if (flush) begin
            // Drop both the in-flight word and the held word; idle outputs
            // come from the defaults above.
            state_nxt     = IDLE;
            hold_full_nxt = 1'b0;
        end else if (load_point) begin
            if (hold_full) begin
                // Held word is older than anything arriving now, so it goes
                // first; a coincident arrival refills the hold register.
                do_load       = 1'b1;
                load_word     = hold_reg;
                hold_full_nxt = handshake;
                if (handshake) begin
                    hold_nxt = in_data;
                end
            end else if (handshake) begin
                // Nothing waiting: bypass the hold register.
                do_load   = 1'b1;
                load_word = in_data;
            end else begin
                state_nxt = IDLE;
            end
        end else begin
            // Mid-word: keep shifting, park any arriving word in hold.
            if (handshake) begin
                hold_nxt      = in_data;
                hold_full_nxt = 1'b1;
            end
            sel_nxt        = sel_inc;
            din_nxt        = shift_reg[sel_inc];
            active_nxt     = 1'b1;
            frame_done_nxt = (sel_inc == LAST_SEL);
        end

        if (do_load) begin
            state_nxt       = SHIFT;
            shift_nxt       = load_word;
            sel_nxt         = '0;
            din_nxt         = load_word[0];
            active_nxt      = 1'b1;
            frame_start_nxt = 1'b1;
            // A one-channel word starts and ends on the same cycle.
            frame_done_nxt  = (NUM_CH == 1);
        end
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            din         <= 1'b0;
            sel         <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_reg   <= shift_nxt;
            hold_reg    <= hold_nxt;
            hold_full   <= hold_full_nxt;
            din         <= din_nxt;
            sel         <= sel_nxt;
            active      <= active_nxt;
            frame_start <= frame_start_nxt;
            frame_done  <= frame_done_nxt;
        end
    end

endmodule
